main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit for the cached RISC-V core. Sequences each RV32I instruction through fetch, decode, execute, memory and write-back. Drives the `aluOP`/`OP_f7` pair consumed by the ALU decoder, plus datapath mux selects and register/PC write strobes. Handshakes with the cache through a req/ready pair, so cache misses stall the sequence without losing state.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0: cycles to wait for `mem_ready` before flagging `mem_timeout`. A value of 0 disables the check.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  7  IR[6:0]; stable from DECODE onward
- `funct3`  in  3  IR[14:12]
- `funct7_b5`  in  1  IR[30]
- `branch_taken`  in  1  branch comparison result from the datapath; valid in EXEC
- `mem_ready`  in  1  cache has completed the current access
- `mem_req`  out  1  access request; held high until `mem_ready`
- `mem_we`  out  1  store access
- `mem_is_fetch`  out  1  access is an instruction fetch
- `ir_write`  out  1  load IR from fetch data
- `pc_write`  out  1  update PC
- `pc_src`  out  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1
- `reg_write`  out  1  register-file write enable
- `result_src`  out  2  write-back source: 0 = ALU result register, 1 = memory data, 2 = pc+4
- `alu_src_a`  out  2  ALU operand A: 0 = rs1, 1 = pc, 2 = zero
- `alu_src_b`  out  1  ALU operand B: 0 = rs2, 1 = imm
- `imm_src`  out  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J
- `aluOP`  out  2  ALU decoder class: 00 = add, 01 = branch, 10 = R/I arithmetic
- `OP_f7`  out  1  funct7 modifier forwarded to the ALU decoder
- `illegal_instr`  out  1  one-cycle pulse on an unsupported opcode
- `mem_timeout`  out  1  sticky flag; cleared only by reset
- `state`  out  3  current state, for debug

## Operation
States: RESET(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), WB(5).

- **RESET**: entered on `rst_n`=0. All outputs are 0. Moves to FETCH on the first clock after reset deasserts.
- **FETCH**: `mem_req` = `mem_is_fetch` = 1. Stays in FETCH while `mem_ready`=0. In the cycle `mem_ready`=1, `ir_write`=1, then moves to DECODE.
- **DECODE**: classifies `opcode` and latches the result into a class register (R, I_ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, ILLEGAL).
  - ILLEGAL: pulse `illegal_instr`, `pc_write`=1, `pc_src`=0, then go to FETCH.
  - Otherwise go to EXEC.
- **EXEC** (`alu_src_a`, `alu_src_b`, `aluOP`, `imm_src` per class):
  - R: a=0, b=0, `aluOP`=10, `OP_f7`=`funct7_b5`.
  - I_ALU: a=0, b=1, `aluOP`=10. `OP_f7`=`funct7_b5` only when `funct3`=101, otherwise 0 (so ADDI never becomes SUB).
  - LOAD/STORE: a=0, b=1, `aluOP`=00; `imm_src` is I or S.
  - BRANCH: a=0, b=0, `aluOP`=01, `imm_src`=B, `pc_write`=1, `pc_src`=`branch_taken` ? 1 : 0. Then go to FETCH.
  - LUI: a=2, b=1, `aluOP`=00, `imm_src`=U.
  - AUIPC: a=1, b=1, `aluOP`=00, `imm_src`=U.
  - JAL/JALR: `aluOP`=00; `imm_src` is J or I.
  - Next state: LOAD/STORE go to MEM; BRANCH goes to FETCH; all others go to WB.
- **MEM**: `mem_req`=1, `mem_we` = (class is STORE); held until `mem_ready`.
  - STORE: on ready, `pc_write`=1, `pc_src`=0, then go to FETCH.
  - LOAD: on ready, go to WB.
- **WB**: `reg_write`=1.
  - `result_src` = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_write`=1; `pc_src` = 1 for JAL, 2 for JALR, 0 otherwise.
  - Then go to FETCH.
- Outputs are combinational functions of the state register and the class register, plus the fields listed above. Any unlisted output is 0.
- `mem_req` never deasserts before `mem_ready` is seen; `mem_we` and `mem_is_fetch` stay stable while it is held.

## Timing
- Cycle counts with zero-wait memory (ready in the first request cycle):
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - R, I_ALU, LUI, AUIPC, JAL, JALR: 4 cycles
  - LOAD: 5 cycles
  - ILLEGAL: 2 cycles
- Each wait cycle in FETCH or MEM adds exactly one cycle.
- `mem_ready` asserted while `mem_req`=0 is ignored.
- Timeout: with `MEM_TIMEOUT`=N>0, if `mem_req` has been held for N cycles without `mem_ready`, `mem_timeout` sets. The FSM keeps waiting.
- Reset mid-access: the state goes to RESET asynchronously and all strobes drop in the same instant. The outstanding access is abandoned, and the next access is a fetch.
- `pc_write` and `reg_write` are single-cycle per instruction; they are never both asserted outside WB.

## Structure
- Shared package `ctrl_pkg`: state encoding, instruction-class enum, `aluOP` codes (00/01/10), and the `pc_src`, `result_src`, `alu_src_a` and `imm_src` encodings. These are shared with the datapath and the ALU decoder.
- Sub-module `instr_class_decode`: combinational `opcode` → class, with unknown opcodes mapped to ILLEGAL. The FSM instantiates it and registers its output in DECODE.

## Test plan
- ADD x3,x1,x2 (opcode 0110011, f3=000, f7b5=0), zero-wait memory → states 1,2,3,5,1; `aluOP`=10, `OP_f7`=0 in EXEC; `reg_write` pulse in cycle 4.
- ADDI with IR[30]=1, f3=000 → `OP_f7`=0. SRAI with IR[30]=1, f3=101 → `OP_f7`=1.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_req`=1 and `mem_we`=0 held 4 cycles; `result_src`=1 in WB; total 8 cycles.
- BEQ with `branch_taken`=1 → `aluOP`=01, `pc_src`=1, `pc_write`=1 in EXEC; 3 cycles total, no `reg_write`.
- Opcode 0000000 → `illegal_instr` pulse in DECODE with `pc_src`=0, then FETCH. With `MEM_TIMEOUT`=4 and `mem_ready` stuck low → `mem_timeout` sets after 4 cycles.
- `rst_n` low during MEM of a store → `mem_req`/`mem_we` drop immediately; state=0; the first request after release has `mem_is_fetch`=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control encodings: FSM states, instruction classes and the
// select/opcode codes seen by the datapath and the ALU decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_I_ALU, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_ILLEGAL
  } iclass_t;

  // RV32I major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU decoder class
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;

  // PC source
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  // Write-back source
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  // ALU operand selects
  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic       SRCB_RS2  = 1'b0;
  localparam logic       SRCB_IMM  = 1'b1;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

endpackage

// File: rtl/instr_class_decode.sv
// Opcode -> instruction class; anything not in RV32I base maps to ILLEGAL.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_t    o_class
);

  // Pure lookup on the major opcode
  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OPC_R:      o_class = CL_R;
      OPC_I_ALU:  o_class = CL_I_ALU;
      OPC_LOAD:   o_class = CL_LOAD;
      OPC_STORE:  o_class = CL_STORE;
      OPC_BRANCH: o_class = CL_BRANCH;
      OPC_LUI:    o_class = CL_LUI;
      OPC_AUIPC:  o_class = CL_AUIPC;
      OPC_JAL:    o_class = CL_JAL;
      OPC_JALR:   o_class = CL_JALR;
      default:    o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// req/ready cache handshake and an optional sticky memory-timeout flag.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] aluOP,
  output logic       OP_f7,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [2:0] state
);

  state_t  r_state, w_next;
  iclass_t r_class, w_class;

  instr_class_decode u_dec (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  assign state = r_state;

  // State register; class is captured once per instruction in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_class <= CL_ILLEGAL;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_class <= w_class;
    end
  end

  // Next state and all control outputs; everything defaults to 0
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_is_fetch  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_PLUS4;
    reg_write     = 1'b0;
    result_src    = RES_ALU;
    alu_src_a     = SRCA_RS1;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    aluOP         = ALUOP_ADD;
    OP_f7         = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      ST_RESET: w_next = ST_FETCH;
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      // ILLEGAL is resolved straight from the decoder so it costs no EXEC slot
      ST_DECODE: begin
        if (w_class == CL_ILLEGAL) begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
          pc_src        = PC_PLUS4;
          w_next        = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next = ST_WB;
        case (r_class)
          CL_R: begin
            aluOP = ALUOP_ARITH;
            OP_f7 = funct7_b5;
          end
          CL_I_ALU: begin
            alu_src_b = SRCB_IMM;
            aluOP     = ALUOP_ARITH;
            // IR[30] is a real modifier only for SRLI/SRAI; for ADDI it is imm bits
            OP_f7     = (funct3 == 3'b101) ? funct7_b5 : 1'b0;
          end
          CL_LOAD: begin
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_I;
            w_next    = ST_MEM;
          end
          CL_STORE: begin
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_S;
            w_next    = ST_MEM;
          end
          CL_BRANCH: begin
            aluOP    = ALUOP_BRANCH;
            imm_src  = IMM_B;
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_TARGET : PC_PLUS4;
            w_next   = ST_FETCH;
          end
          CL_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
          end
          CL_AUIPC: begin
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
          end
          CL_JAL:  imm_src = IMM_J;
          CL_JALR: imm_src = IMM_I;
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_class == CL_STORE);
        if (mem_ready) begin
          if (r_class == CL_STORE) begin
            pc_write = 1'b1;
            pc_src   = PC_PLUS4;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (r_class)
          CL_LOAD: result_src = RES_MEM;
          CL_JAL: begin
            result_src = RES_PC4;
            pc_src     = PC_TARGET;
          end
          CL_JALR: begin
            result_src = RES_PC4;
            pc_src     = PC_JALR;
          end
          default: result_src = RES_ALU;
        endcase
        w_next = ST_FETCH;
      end
      default: w_next = ST_RESET;
    endcase
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_tmo
      localparam int             CW    = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0]  LIMIT = CW'(MEM_TIMEOUT - 1);
      logic [CW-1:0] r_wait_cnt;
      logic          r_timeout;

      // Count consecutive unanswered request cycles; flag is sticky until reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wait_cnt <= '0;
          r_timeout  <= 1'b0;
        end else if (mem_req && !mem_ready) begin
          if (r_wait_cnt == LIMIT) r_timeout  <= 1'b1;
          else                     r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
          r_wait_cnt <= '0;
        end
      end

      assign mem_timeout = r_timeout;
    end else begin : g_no_tmo
      assign mem_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// vector, then the queue is drained one cycle at a time against the DUT.
module tb_main_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, fetch, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rs, sa;
    logic       sb;
    logic [2:0] imm;
    logic [1:0] aop;
    logic       f7, ill, tmo;
  } ctl_t;

  typedef struct {
    string tag;
    logic  rdy;
    logic  bt;
    ctl_t  exp;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5, branch_taken, mem_ready;
  logic       mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, result_src, alu_src_a, aluOP;
  logic       alu_src_b, OP_f7, illegal_instr, mem_timeout;
  logic [2:0] imm_src, state;

  ent_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic tmo_exp = 1'b0;
  ctl_t obs;

  main_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7_b5(funct7_b5), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .aluOP(aluOP), .OP_f7(OP_f7),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, mem_is_fetch, ir_write, pc_write,
                pc_src, reg_write, result_src, alu_src_a, alu_src_b, imm_src,
                aluOP, OP_f7, illegal_instr, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ctl_t z(input logic [2:0] st);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.tmo = tmo_exp;
    return c;
  endfunction

  task automatic push(input string tag, input logic rdy, input logic bt, input ctl_t c);
    ent_t e;
    e.tag = tag; e.rdy = rdy; e.bt = bt; e.exp = c;
    sbq.push_back(e);
  endtask

  // Drain: drive each cycle's inputs on the falling edge, compare 1ns later
  task automatic run_q();
    ent_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      mem_ready    = e.rdy;
      branch_taken = e.bt;
      #1;
      chk(e.tag, 32'(obs), 32'(e.exp));
    end
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_b5 = f7;
  endtask

  task automatic fetch(input int nw);
    ctl_t c;
    c = z(3'd1); c.req = 1; c.fetch = 1;
    for (int i = 0; i < nw; i++) push("fetch_wait", 1'b0, 1'b0, c);
    c.irw = 1;
    push("fetch", 1'b1, 1'b0, c);
  endtask

  task automatic dec();
    push("decode", 1'b1, 1'b0, z(3'd2));
  endtask

  task automatic ex(input string tag, input logic [1:0] sa, input logic sb,
                    input logic [2:0] imm, input logic [1:0] aop, input logic f7);
    ctl_t c;
    c = z(3'd3); c.sa = sa; c.sb = sb; c.imm = imm; c.aop = aop; c.f7 = f7;
    push(tag, 1'b1, 1'b0, c);
  endtask

  task automatic wb(input string tag, input logic [1:0] rs, input logic [1:0] pcs);
    ctl_t c;
    c = z(3'd5); c.rw = 1; c.pcw = 1; c.rs = rs; c.pcs = pcs;
    push(tag, 1'b1, 1'b0, c);
  endtask

  initial begin
    ctl_t c;
    rst_n = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    instr(7'b0110011, 3'b000, 1'b0);
    @(negedge clk); #1;
    chk("reset", 32'(obs), 32'(z(3'd0)));
    #1 rst_n = 1'b1;
    #1 chk("rst_release", 32'(obs), 32'(z(3'd0)));

    // ADD x3,x1,x2
    fetch(0); dec(); ex("add_exec", 2'd0, 1'b0, 3'd0, 2'b10, 1'b0); wb("add_wb", 2'd0, 2'd0);
    run_q();
    // SUB
    instr(7'b0110011, 3'b000, 1'b1);
    fetch(0); dec(); ex("sub_exec", 2'd0, 1'b0, 3'd0, 2'b10, 1'b1); wb("sub_wb", 2'd0, 2'd0);
    run_q();
    // ADDI with IR[30]=1 and two fetch wait cycles
    instr(7'b0010011, 3'b000, 1'b1);
    fetch(2); dec(); ex("addi_exec", 2'd0, 1'b1, 3'd0, 2'b10, 1'b0); wb("addi_wb", 2'd0, 2'd0);
    run_q();
    // SRAI
    instr(7'b0010011, 3'b101, 1'b1);
    fetch(0); dec(); ex("srai_exec", 2'd0, 1'b1, 3'd0, 2'b10, 1'b1); wb("srai_wb", 2'd0, 2'd0);
    run_q();
    // LW with 3 wait cycles in MEM
    instr(7'b0000011, 3'b010, 1'b0);
    fetch(0); dec(); ex("lw_exec", 2'd0, 1'b1, 3'd0, 2'b00, 1'b0);
    c = z(3'd4); c.req = 1;
    for (int i = 0; i < 3; i++) push("lw_mem_wait", 1'b0, 1'b0, c);
    push("lw_mem", 1'b1, 1'b0, c);
    wb("lw_wb", 2'd1, 2'd0);
    run_q();
    // SW with one MEM wait
    instr(7'b0100011, 3'b010, 1'b0);
    fetch(0); dec(); ex("sw_exec", 2'd0, 1'b1, 3'd1, 2'b00, 1'b0);
    c = z(3'd4); c.req = 1; c.we = 1;
    push("sw_mem_wait", 1'b0, 1'b0, c);
    c.pcw = 1;
    push("sw_mem", 1'b1, 1'b0, c);
    run_q();
    // BEQ taken, then not taken
    instr(7'b1100011, 3'b000, 1'b0);
    fetch(0); dec();
    c = z(3'd3); c.aop = 2'b01; c.imm = 3'd2; c.pcw = 1; c.pcs = 2'd1;
    push("beq_taken", 1'b1, 1'b1, c);
    fetch(0); dec();
    c.pcs = 2'd0;
    push("beq_not_taken", 1'b1, 1'b0, c);
    run_q();
    // LUI, AUIPC
    instr(7'b0110111, 3'b000, 1'b0);
    fetch(0); dec(); ex("lui_exec", 2'd2, 1'b1, 3'd3, 2'b00, 1'b0); wb("lui_wb", 2'd0, 2'd0);
    run_q();
    instr(7'b0010111, 3'b000, 1'b0);
    fetch(0); dec(); ex("auipc_exec", 2'd1, 1'b1, 3'd3, 2'b00, 1'b0); wb("auipc_wb", 2'd0, 2'd0);
    run_q();
    // JAL, JALR
    instr(7'b1101111, 3'b000, 1'b0);
    fetch(0); dec(); ex("jal_exec", 2'd0, 1'b0, 3'd4, 2'b00, 1'b0); wb("jal_wb", 2'd2, 2'd1);
    run_q();
    instr(7'b1100111, 3'b000, 1'b0);
    fetch(0); dec(); ex("jalr_exec", 2'd0, 1'b0, 3'd0, 2'b00, 1'b0); wb("jalr_wb", 2'd2, 2'd2);
    run_q();
    // Illegal opcode: 2 cycles, back to FETCH
    instr(7'b0000000, 3'b000, 1'b0);
    fetch(0);
    c = z(3'd2); c.ill = 1; c.pcw = 1;
    push("illegal_decode", 1'b1, 1'b0, c);
    fetch(0);
    run_q();

    // Reset while a store waits in MEM
    instr(7'b0100011, 3'b010, 1'b0);
    dec(); ex("sw2_exec", 2'd0, 1'b1, 3'd1, 2'b00, 1'b0);
    c = z(3'd4); c.req = 1; c.we = 1;
    push("sw2_mem_wait", 1'b0, 1'b0, c);
    run_q();
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'(z(3'd0)));
    @(negedge clk); #2 rst_n = 1'b1;
    #1 chk("rst_release2", 32'(obs), 32'(z(3'd0)));
    instr(7'b0110011, 3'b000, 1'b0);
    fetch(0); dec(); ex("add2_exec", 2'd0, 1'b0, 3'd0, 2'b10, 1'b0); wb("add2_wb", 2'd0, 2'd0);
    run_q();

    // Fetch stuck: flag sets after 4 unanswered cycles and stays set
    c = z(3'd1); c.req = 1; c.fetch = 1;
    for (int i = 0; i < 4; i++) push("tmo_wait_pre", 1'b0, 1'b0, c);
    run_q();
    tmo_exp = 1'b1;
    c = z(3'd1); c.req = 1; c.fetch = 1;
    for (int i = 0; i < 2; i++) push("tmo_wait_post", 1'b0, 1'b0, c);
    fetch(0); dec(); ex("tmo_exec", 2'd0, 1'b0, 3'd0, 2'b10, 1'b0); wb("tmo_wb", 2'd0, 2'd0);
    run_q();
    tmo_exp = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("tmo_cleared", 32'(obs), 32'(z(3'd0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
